// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the default mul/div occupancy of EX.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MULDIV  = 2'd1,
        MEMWAIT = 2'd2
    } state_e;

    localparam int MULDIV_LAT_DEFAULT = 4;
    localparam int MDCNT_W            = 6;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in ID/EX whose destination is read by the instruction in IF/ID.
module load_use_detect #(
    parameter int REGINDEX = 5
) (
    input  logic [REGINDEX-1:0] ifid_rs1,
    input  logic [REGINDEX-1:0] ifid_rs2,
    input  logic                ifid_use_rs1,
    input  logic                ifid_use_rs2,
    input  logic [REGINDEX-1:0] idex_rd,
    input  logic                idex_memread,
    output logic                hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = ifid_use_rs1 && (ifid_rs1 == idex_rd);
    assign rs2_hit = ifid_use_rs2 && (ifid_rs2 == idex_rd);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard = idex_memread && (idex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/flush controller: load-use bubbles, branch squashes,
// mul/div occupancy of EX, data-memory wait states and a stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGINDEX   = 5,
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
    parameter int CNTW       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REGINDEX-1:0] ifid_rs1,
    input  logic [REGINDEX-1:0] ifid_rs2,
    input  logic                ifid_use_rs1,
    input  logic                ifid_use_rs2,
    input  logic [REGINDEX-1:0] idex_rd,
    input  logic                idex_memread,
    input  logic                ex_branch_taken,
    input  logic                ex_muldiv_start,
    input  logic                dmem_req,
    input  logic                dmem_ready,
    output logic                pc_en,
    output logic                ifid_en,
    output logic                idex_en,
    output logic                exmem_en,
    output logic                memwb_en,
    output logic                ifid_flush,
    output logic                idex_flush,
    output logic                exmem_flush,
    output logic                muldiv_done,
    output logic                busy,
    output logic [CNTW-1:0]     stall_cycles
);

    localparam logic [MDCNT_W-1:0] MULDIV_LOAD = MDCNT_W'(MULDIV_LAT - 1);

    state_e             state_q, state_d;
    logic [MDCNT_W-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0]    stall_q, stall_d;

    logic load_use;
    logic eval_run;
    logic mem_stall;

    load_use_detect #(
        .REGINDEX (REGINDEX)
    ) u_load_use_detect (
        .ifid_rs1     (ifid_rs1),
        .ifid_rs2     (ifid_rs2),
        .ifid_use_rs1 (ifid_use_rs1),
        .ifid_use_rs2 (ifid_use_rs2),
        .idex_rd      (idex_rd),
        .idex_memread (idex_memread),
        .hazard       (load_use)
    );

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        eval_run    = 1'b0;
        mem_stall   = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        muldiv_done = 1'b0;

        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    eval_run  = 1'b1;
                    mem_stall = dmem_req && !dmem_ready;
                end
                MULDIV: begin
                    if (cnt_q != '0) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        cnt_d       = cnt_q - 1'b1;
                    end else begin
                        muldiv_done = 1'b1;
                        state_d     = RUN;
                    end
                end
                MEMWAIT: begin
                    // The ready cycle replays the RUN rules against the held EX inputs.
                    if (dmem_ready) begin
                        eval_run = 1'b1;
                    end else begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                        memwb_en = 1'b0;
                    end
                end
                default: state_d = RUN;
            endcase

            if (eval_run) begin
                state_d = RUN;
                if (mem_stall) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    state_d  = MEMWAIT;
                end else if (ex_muldiv_start) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    cnt_d       = MULDIV_LOAD;
                    state_d     = MULDIV;
                end else if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign busy         = (state_q != RUN);
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expected control vectors go through a
// scoreboard queue and are compared mid-cycle against the DUT.
module tb_pipe_hazard_ctrl;

    localparam int RI  = 5;
    localparam int LAT = 4;
    localparam int CW  = 4;

    // Control vector order: pc,ifid,idex,exmem,memwb enables | ifid,idex,exmem flushes | done | busy
    localparam logic [9:0] C_RUN    = 10'b11111_000_0_0;
    localparam logic [9:0] C_LU     = 10'b00111_010_0_0;
    localparam logic [9:0] C_BR     = 10'b11111_110_0_0;
    localparam logic [9:0] C_MD0    = 10'b00011_001_0_0;
    localparam logic [9:0] C_MDB    = 10'b00011_001_0_1;
    localparam logic [9:0] C_MDDONE = 10'b11111_000_1_1;
    localparam logic [9:0] C_MEM0   = 10'b00000_000_0_0;
    localparam logic [9:0] C_MEMW   = 10'b00000_000_0_1;
    localparam logic [9:0] C_RELBR  = 10'b11111_110_0_1;
    localparam logic [9:0] C_BUSY   = 10'b11111_000_0_1;

    logic          clk = 1'b0;
    logic          rst;
    logic [RI-1:0] ifid_rs1, ifid_rs2, idex_rd;
    logic          ifid_use_rs1, ifid_use_rs2, idex_memread;
    logic          ex_branch_taken, ex_muldiv_start, dmem_req, dmem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush, muldiv_done, busy;
    logic [CW-1:0] stall_cycles;
    logic [9:0]    obs_ctl;

    typedef struct {
        string         tag;
        logic [9:0]    ctl;
        logic [CW-1:0] stall;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [CW-1:0] exp_stall;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REGINDEX   (RI),
        .MULDIV_LAT (LAT),
        .CNTW       (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ifid_rs1        (ifid_rs1),
        .ifid_rs2        (ifid_rs2),
        .ifid_use_rs1    (ifid_use_rs1),
        .ifid_use_rs2    (ifid_use_rs2),
        .idex_rd         (idex_rd),
        .idex_memread    (idex_memread),
        .ex_branch_taken (ex_branch_taken),
        .ex_muldiv_start (ex_muldiv_start),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .muldiv_done     (muldiv_done),
        .busy            (busy),
        .stall_cycles    (stall_cycles)
    );

    assign obs_ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush, muldiv_done, busy};

    task automatic clear_in();
        ifid_rs1        = '0;
        ifid_rs2        = '0;
        ifid_use_rs1    = 1'b0;
        ifid_use_rs2    = 1'b0;
        idex_rd         = '0;
        idex_memread    = 1'b0;
        ex_branch_taken = 1'b0;
        ex_muldiv_start = 1'b0;
        dmem_req        = 1'b0;
        dmem_ready      = 1'b0;
    endtask

    // Push the expectation, compare on the falling edge, then advance the model's stall count.
    task automatic step(input string tag, input logic [9:0] ctl);
        exp_t e;
        e.tag   = tag;
        e.ctl   = ctl;
        e.stall = exp_stall;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        assert (obs_ctl === e.ctl) n_pass++;
        else $error("FAIL %s ctl: got %b want %b", e.tag, obs_ctl, e.ctl);
        n_checks++;
        assert (stall_cycles === e.stall) n_pass++;
        else $error("FAIL %s stall_cycles: got %0d want %0d", e.tag, stall_cycles, e.stall);
        if (rst) exp_stall = '0;
        else if (!ctl[9] && (exp_stall != '1)) exp_stall = exp_stall + 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        rst       = 1'b1;
        exp_stall = '0;
        @(posedge clk);
        #1;
        step("reset", C_RUN);
        rst = 1'b0;
        step("idle", C_RUN);

        // Load x5 then an add reading rs2=x5
        idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_use_rs2 = 1'b1;
        step("lu_rs2", C_LU);
        clear_in();
        step("lu_after", C_RUN);

        // Load to x0 never stalls
        idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_use_rs1 = 1'b1;
        ifid_rs2 = 5'd0; ifid_use_rs2 = 1'b1;
        step("lu_x0", C_RUN);
        clear_in();

        idex_memread = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_use_rs1 = 1'b1;
        step("lu_rs1", C_LU);
        ifid_use_rs1 = 1'b0;
        step("lu_rs1_unused", C_RUN);
        ifid_use_rs1 = 1'b1; idex_memread = 1'b0;
        step("no_load", C_RUN);

        // Branch squashes a would-be load-use hazard
        idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_use_rs2 = 1'b1;
        ex_branch_taken = 1'b1;
        step("br_lu", C_BR);
        clear_in();

        // Mul/div occupancy; branch and memory wait are ignored while busy
        ex_muldiv_start = 1'b1;
        step("md_c0", C_MD0);
        ex_branch_taken = 1'b1; dmem_req = 1'b1;
        step("md_c1", C_MDB);
        step("md_c2", C_MDB);
        step("md_c3", C_MDB);
        step("md_c4_done", C_MDDONE);
        clear_in();
        step("md_c5", C_RUN);

        // Memory ready in the same cycle as the request
        dmem_req = 1'b1; dmem_ready = 1'b1;
        step("mem_fast", C_RUN);
        clear_in();

        // Three wait cycles with a branch held pending
        dmem_req = 1'b1; ex_branch_taken = 1'b1;
        step("mw_c0", C_MEM0);
        step("mw_c1", C_MEMW);
        step("mw_c2", C_MEMW);
        dmem_ready = 1'b1;
        step("mw_release", C_RELBR);
        clear_in();
        step("mw_after", C_RUN);

        // Reset in the middle of a mul/div
        ex_muldiv_start = 1'b1;
        step("mdr_c0", C_MD0);
        step("mdr_c1", C_MDB);
        rst = 1'b1; ex_muldiv_start = 1'b0;
        step("mdr_rst", C_BUSY);
        rst = 1'b0;
        step("mdr_after", C_RUN);
        step("mdr_no_done", C_RUN);

        // Long memory wait drives the 4-bit counter into saturation
        dmem_req = 1'b1;
        step("sat_c0", C_MEM0);
        for (int i = 1; i < 18; i++) begin
            step("sat_wait", C_MEMW);
        end
        dmem_ready = 1'b1;
        step("sat_release", C_BUSY);
        clear_in();
        step("sat_hold", C_RUN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
